spi_byte_tx: RTL and testbench
==============================

Name: spi_byte_tx

Overview:
- Unified SPI byte serializer that drives the panel pins for one command or data byte per request.
- Sits directly downstream of the clear/draw sequencers and replaces the separate command and data serializers.
- A sequencer presents a byte, its D/C flag and an optional post-byte delay request with a one-cycle write strobe.
- The block generates CS, SCLK, MOSI and D/C, then returns a one-cycle done pulse.

Parameters:
CLK_DIV, 2, SCLK half-period in i_clk cycles (legal values: 1 or more).
DELAY, 2_700_000, i_clk cycles of post-byte wait when i_need_delay was set (used after SWRESET/SLPOUT); 0 means no wait.

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous active-high reset
i_data  input  8  byte to send; MSB is sent first
i_dc  input  1  0 = command, 1 = data; latched with i_we
i_we  input  1  one-cycle request strobe; accepted only while o_busy=0
i_need_delay  input  1  latched with i_we; inserts DELAY wait after the byte
o_mosi  output  1  serial data
o_sclk  output  1  SPI clock, mode 0 (idles low, panel samples on rising edge)
o_cs  output  1  chip select, active low
o_dc  output  1  D/C pin
o_done  output  1  one-cycle pulse when the byte (and any delay) is complete
o_busy  output  1  high from the acceptance edge until the cycle o_done is asserted

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst is asynchronous and active-high.
- Reset values: o_cs=1, o_sclk=0, o_mosi=0, o_dc=0, o_done=0, o_busy=0; FSM in IDLE.
- Reset mid-transfer aborts immediately: CS goes high asynchronously and the delay counter clears.
- FSM states: IDLE, SETUP, SHIFT, HOLD, WAIT, then back to IDLE.
- IDLE: if i_we=1 on an edge (call it t0), latch i_data, i_dc and i_need_delay into a shift register and flags. At t0 also drive o_cs<=0, o_dc<=i_dc, o_mosi<=i_data[7], o_busy<=1, then go to SETUP.
- Later changes to i_data, i_dc or i_need_delay have no effect on the byte in flight.
- SETUP: hold SCLK low for CLK_DIV cycles.
- SHIFT (8 bits): SCLK rises at edge t0+CLK_DIV*(1+2k) and falls at t0+CLK_DIV*(2+2k), for k=0..7.
- MOSI changes only at falling edges, shifting in the next bit (bit 7-k-1).
- After the 8th fall (t0+16*CLK_DIV), MOSI holds the last bit and the FSM goes to HOLD.
- HOLD: keep CS low for CLK_DIV cycles, then o_cs<=1 at t0+17*CLK_DIV.
- Next state: WAIT if the latched need_delay=1 and DELAY>0, otherwise IDLE.
- WAIT: count DELAY cycles with CS high, then go to IDLE. Counter width is $clog2(DELAY+1).
- Completion: o_done=1 and o_busy=0 on the single cycle after entry to IDLE.
  - Without delay: registered at edge t0+17*CLK_DIV+1.
  - With delay: registered at edge t0+17*CLK_DIV+1+DELAY.
- Back-to-back requests: i_we is accepted on the same cycle o_done is high, so a new byte's t0 can be that edge.
- i_we while o_busy=1 is ignored silently; no queueing.
- o_dc is held from acceptance until the next acceptance. It stays valid after CS rises, which lets sequencers read it.
- o_sclk is 0 whenever o_cs=1.

Test Plan:
- Reset, then idle 10 cycles -> o_cs=1, o_sclk=0, o_mosi=0, o_dc=0, o_done=0, o_busy=0 throughout.
- CLK_DIV=2, send i_data=8'h2A, i_dc=0, need_delay=0 -> checks:
  - 8 rising SCLK edges; bits sampled at rising edges are 0,0,1,0,1,0,1,0.
  - o_cs low from t0 to t0+34; o_done pulses at t0+35; o_dc=0.
- DELAY=20, send 8'h01 with need_delay=1 -> CS rises at t0+34; o_done at t0+55; o_busy high until then.
- Back-to-back: assert i_we with 8'hEF, i_dc=1 in the o_done cycle of the previous byte -> second CS low starts on that edge; o_dc=1; bits 1,1,1,0,1,1,1,1.
- i_we pulsed mid-transfer with 8'hFF -> ignored: the in-flight byte is unchanged and exactly one o_done is produced.
- Assert i_rst at bit 4 of a transfer -> o_cs=1 and o_sclk=0 immediately, no o_done. The next i_we after reset transmits cleanly.

Source files
------------

// File: rtl/spi_byte_tx.sv
// spi_byte_tx: sends one command or data byte to the panel, MSB first, in SPI mode 0.
// A sequencer strobes i_we with a byte, its D/C flag and an optional post-byte delay request.
// The block then drives CS, SCLK, MOSI and D/C, and afterwards returns a one-cycle o_done.
//
// Ports:
//   i_clk, i_rst   clock; asynchronous active-high reset
//   i_data[7:0]    byte to send (MSB first)
//   i_dc           0 = command, 1 = data; latched with i_we
//   i_we           one-cycle request strobe; accepted only while o_busy=0
//   i_need_delay   latched with i_we; adds DELAY idle cycles after the byte
//   o_mosi, o_sclk, o_cs, o_dc   panel pins (CS active low, SCLK idles low)
//   o_done         one-cycle completion pulse
//   o_busy         high from the acceptance edge until the o_done cycle
//
// Handshake: a request is taken on a rising edge where i_we=1 and o_busy=0. Otherwise it is
// dropped without any effect. No request is queued. o_done and o_busy=0 appear together for a
// single cycle, and a request can be accepted on the edge that ends that cycle.
module spi_byte_tx #(
  parameter int CLK_DIV = 2,
  parameter int DELAY   = 2_700_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_dc,
  input  logic       i_we,
  input  logic       i_need_delay,
  output logic       o_mosi,
  output logic       o_sclk,
  output logic       o_cs,
  output logic       o_dc,
  output logic       o_done,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_WAIT
  } state_t;

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DLY_LAST = DW'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic          HAS_DELAY = (DELAY > 0);

  state_t        state_q, state_d;
  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  // Only the seven bits still to be sent are kept. Bit 7 goes straight onto MOSI at acceptance.
  logic [6:0]    sh_q, sh_d;
  logic          need_dly_q, need_dly_d;
  logic [DW-1:0] dly_cnt_q, dly_cnt_d;
  logic          mosi_q, mosi_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          dc_q, dc_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    need_dly_d = need_dly_q;
    dly_cnt_d  = dly_cnt_q;
    mosi_d     = mosi_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    dc_d       = dc_q;
    done_d     = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        if (busy_q) begin
          // First cycle back in IDLE: finish the previous byte.
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (i_we) begin
          sh_d       = i_data[6:0];
          need_dly_d = i_need_delay;
          cs_d       = 1'b0;
          dc_d       = i_dc;
          mosi_d     = i_data[7];
          busy_d     = 1'b1;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
          state_d    = S_SETUP;
        end
      end

      S_SETUP: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = 1'b1;
          state_d   = S_SHIFT;
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end

      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (sclk_q) begin
            // Falling edge. MOSI moves here so the panel sees stable data at the next rise.
            sclk_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              mosi_d    = sh_q[6];
              sh_d      = {sh_q[5:0], 1'b0};
            end
          end else begin
            sclk_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end

      S_HOLD: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          cs_d      = 1'b1;
          dly_cnt_d = '0;
          state_d   = (need_dly_q && HAS_DELAY) ? S_WAIT : S_IDLE;
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end

      S_WAIT: begin
        if (dly_cnt_q == DLY_LAST) begin
          state_d = S_IDLE;
        end else begin
          dly_cnt_d = dly_cnt_q + DW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      need_dly_q <= 1'b0;
      dly_cnt_q  <= '0;
      mosi_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      dc_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      need_dly_q <= need_dly_d;
      dly_cnt_q  <= dly_cnt_d;
      mosi_q     <= mosi_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      dc_q       <= dc_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign o_mosi = mosi_q;
  assign o_sclk = sclk_q;
  assign o_cs   = cs_q;
  assign o_dc   = dc_q;
  assign o_done = done_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_spi_byte_tx.sv
// Testbench for spi_byte_tx with CLK_DIV=2 and DELAY=20.
// The driver pushes the expected byte, D/C value and timing for each accepted request.
// A negedge monitor rebuilds the byte from MOSI at each SCLK rise.
// On o_done, the monitor pops the expected entry and compares.
module tb_spi_byte_tx;
  localparam int CD  = 2;
  localparam int DLY = 20;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_dc;
  logic       i_we;
  logic       i_need_delay;
  logic       o_mosi, o_sclk, o_cs, o_dc, o_done, o_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];      // {dc, byte}
  int         exp_done_q[$]; // cycle number at which o_done is expected
  int         exp_csr_q[$];  // cycle number at which CS is expected to rise

  spi_byte_tx #(.CLK_DIV(CD), .DELAY(DLY)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_data       (i_data),
    .i_dc         (i_dc),
    .i_we         (i_we),
    .i_need_delay (i_need_delay),
    .o_mosi       (o_mosi),
    .o_sclk       (o_sclk),
    .o_cs         (o_cs),
    .o_dc         (o_dc),
    .o_done       (o_done),
    .o_busy       (o_busy)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge. The request is taken on the next posedge (t0).
  task automatic send(input logic [7:0] d, input logic dc, input logic nd);
    int t0;
    i_data = d; i_dc = dc; i_need_delay = nd; i_we = 1'b1;
    @(posedge clk); #1;
    i_we = 1'b0;
    t0 = cyc;
    check("accept_cs", o_cs, 0);
    check("accept_busy", o_busy, 1);
    check("accept_dc", o_dc, dc);
    check("accept_mosi", o_mosi, d[7]);
    exp_q.push_back({dc, d});
    exp_csr_q.push_back(t0 + 17 * CD);
    exp_done_q.push_back(nd ? t0 + 17 * CD + 1 + DLY : t0 + 17 * CD + 1);
    // Inputs changed after acceptance must not disturb the byte in flight.
    i_data = 8'($urandom_range(0, 255));
    i_dc = 1'($urandom_range(0, 1));
    i_need_delay = 1'($urandom_range(0, 1));
  endtask

  // Returns at the negedge where o_done is visible, or after the cycle budget runs out.
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_done && n < 300);
    if (!o_done) check("done_timeout", 1, 0);
  endtask

  // monitor / scoreboard
  logic       prev_sclk = 1'b0;
  logic       prev_cs = 1'b1;
  int         rises = 0;
  logic [7:0] bits = '0;
  int         cs_rise = -1;

  always @(negedge clk) begin
    if (i_rst) begin
      prev_sclk = 1'b0; prev_cs = 1'b1; rises = 0; bits = '0; cs_rise = -1;
    end else begin
      check("sclk_low_when_cs_high", o_sclk & o_cs, 0);
      if (o_sclk && !prev_sclk) begin
        rises++;
        bits = {bits[6:0], o_mosi};
      end
      if (o_cs && !prev_cs) cs_rise = cyc;
      if (o_done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          logic [8:0] e;
          int ed, ec;
          e = exp_q.pop_front();
          ed = exp_done_q.pop_front();
          ec = exp_csr_q.pop_front();
          check("byte", bits, e[7:0]);
          check("dc", o_dc, e[8]);
          check("rises", rises, 8);
          check("done_cycle", cyc, ed);
          check("cs_rise_cycle", cs_rise, ec);
          check("busy_at_done", o_busy, 0);
          check("cs_at_done", o_cs, 1);
        end
        rises = 0;
        bits = '0;
      end else begin
        check("busy", o_busy, exp_q.size() != 0);
      end
      prev_sclk = o_sclk;
      prev_cs = o_cs;
    end
  end

  // stimulus
  initial begin
    i_rst = 1'b1; i_data = '0; i_dc = 1'b0; i_we = 1'b0; i_need_delay = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_cs", o_cs, 1);
      check("rst_sclk", o_sclk, 0);
      check("rst_mosi", o_mosi, 0);
      check("rst_dc", o_dc, 0);
      check("rst_done", o_done, 0);
      check("rst_busy", o_busy, 0);
    end

    // plain command byte
    send(8'h2A, 1'b0, 1'b0);
    wait_done();
    @(negedge clk);

    // byte with post-byte delay
    send(8'h01, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);

    // back-to-back: second request driven during the o_done cycle
    send(8'hA5, 1'b0, 1'b0);
    wait_done();
    send(8'hEF, 1'b1, 1'b0);
    wait_done();
    @(negedge clk);

    // request strobed mid-transfer is ignored
    send(8'h5C, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    i_data = 8'hFF; i_dc = 1'b1; i_we = 1'b1;
    @(negedge clk);
    i_we = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // random bytes, some with delay
    for (int i = 0; i < 4; i++) begin
      send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done();
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // reset while bit 4 is on the wire
    send(8'hC3, 1'b1, 1'b0);
    repeat (19) @(negedge clk);
    check("pre_rst_sclk", o_sclk, 1);
    check("pre_rst_cs", o_cs, 0);
    i_rst = 1'b1;
    #1;
    check("abort_cs", o_cs, 1);
    check("abort_sclk", o_sclk, 0);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    exp_q.delete(); exp_done_q.delete(); exp_csr_q.delete();
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_abort_done", o_done, 0);
    send(8'h96, 1'b0, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
